rx_receiver: RTL and testbench



---
 rtl/rx_receiver.sv | 155 +++++++++++++++
 tb/tb_rx_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_receiver.sv
// Serial frame receiver: hunts preamble/SFD, captures header and payload,
// checks CRC-8 over the payload and presents the frame with status.

// Bit-serial CRC-8, poly 0x07, init 0x00, MSB first.
module crc8_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] crc_out
);

  logic fb;

  assign fb = crc_out[7] ^ data_in;

  // Shift one bit per enabled cycle; clear restarts the remainder.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc_out <= 8'h00;
    end else if (enable) begin
      crc_out <= {crc_out[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
  end

endmodule

module rx_receiver #(
  parameter logic [15:0] SYNC_WORD = 16'hAAAB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_line,
  input  logic [1:0]   my_id,
  output logic [135:0] rx_packet,
  output logic         rx_valid,
  output logic         rx_crc_ok,
  output logic         rx_addr_hit,
  output logic         rx_busy,
  output logic [7:0]   rx_err_cnt
);

  typedef enum logic [2:0] {
    StHunt,
    StHeader,
    StData,
    StCrc,
    StDone
  } state_t;

  state_t         state_q;
  // Only the 15 most recent bits are stored; the live line bit completes the 16-bit window.
  logic [14:0]    window_q;
  logic [7:0]     bit_cnt_q;
  logic [7:0]     hdr_q;
  logic [127:0]   payload_q;
  logic [7:0]     crc_rx_q;

  logic           sync_hit;
  logic [7:0]     data_limit;
  logic [6:0]     pay_idx;
  logic           crc_clear;
  logic           crc_en;
  logic [7:0]     crc_out;

  assign sync_hit   = ({window_q, rx_line} == SYNC_WORD);
  // (len+1)*8-1 == len*8+7
  assign data_limit = {1'b0, hdr_q[3:0], 3'b111};
  assign pay_idx    = 7'd127 - bit_cnt_q[6:0];
  assign crc_clear  = (state_q == StHunt) && sync_hit;
  assign crc_en     = (state_q == StData);

  crc8_serial u_crc (
    .clk     (clk),
    .rst     (rst),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (rx_line),
    .crc_out (crc_out)
  );

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      window_q    <= '0;
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      payload_q   <= '0;
      crc_rx_q    <= '0;
      rx_packet   <= '0;
      rx_valid    <= 1'b0;
      rx_crc_ok   <= 1'b0;
      rx_addr_hit <= 1'b0;
      rx_busy     <= 1'b0;
      rx_err_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        StHunt: begin
          window_q <= {window_q[13:0], rx_line};
          if (sync_hit) begin
            state_q   <= StHeader;
            bit_cnt_q <= '0;
            payload_q <= '0;
            rx_busy   <= 1'b1;
          end
        end
        StHeader: begin
          hdr_q <= {hdr_q[6:0], rx_line};
          if (bit_cnt_q == 8'd7) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 8'd1;
          end
        end
        StData: begin
          payload_q[pay_idx] <= rx_line;
          if (bit_cnt_q == data_limit) begin
            state_q   <= StCrc;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 8'd1;
          end
        end
        StCrc: begin
          crc_rx_q <= {crc_rx_q[6:0], rx_line};
          if (bit_cnt_q == 8'd7) begin
            state_q   <= StDone;
            bit_cnt_q <= '0;
            rx_busy   <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 8'd1;
          end
        end
        StDone: begin
          rx_packet   <= {hdr_q, payload_q};
          rx_valid    <= 1'b1;
          rx_crc_ok   <= (crc_rx_q == crc_out);
          rx_addr_hit <= (hdr_q[7:6] == my_id);
          if ((crc_rx_q != crc_out) && (rx_err_cnt != 8'hFF)) begin
            rx_err_cnt <= rx_err_cnt + 8'd1;
          end
          // Clearing the window forces a full re-hunt of the next sync.
          window_q    <= '0;
          state_q     <= StHunt;
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_receiver.sv
// Self-checking bench for rx_receiver: directed and random frames compared
// against a byte-level reference model.
module tb_rx_receiver;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_line;
  logic [1:0]   my_id;
  logic [135:0] rx_packet;
  logic         rx_valid;
  logic         rx_crc_ok;
  logic         rx_addr_hit;
  logic         rx_busy;
  logic [7:0]   rx_err_cnt;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [7:0] model_err = 8'h00;

  typedef struct {
    logic [135:0] pkt;
    logic         ok;
    logic         hit;
    logic [7:0]   err;
    int unsigned  cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  rec_t mon_r;

  rx_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .rx_line     (rx_line),
    .my_id       (my_id),
    .rx_packet   (rx_packet),
    .rx_valid    (rx_valid),
    .rx_crc_ok   (rx_crc_ok),
    .rx_addr_hit (rx_addr_hit),
    .rx_busy     (rx_busy),
    .rx_err_cnt  (rx_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      mon_r.pkt = rx_packet;
      mon_r.ok  = rx_crc_ok;
      mon_r.hit = rx_addr_hit;
      mon_r.err = rx_err_cnt;
      mon_r.cyc = cyc;
      obs_q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-wise CRC-8 (poly 0x07, init 0) over the first n payload bytes.
  function automatic logic [7:0] crc8_model(input logic [127:0] pl, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ pl[127-8*i -: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Drive one frame; abort_at >= 0 pulses reset at that bit index instead of finishing.
  task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pl,
                            input logic [7:0] crc_tx, input int gap, input int abort_at);
    logic        bits[$];
    logic [23:0] sync;
    int          n;
    logic [127:0] mask;
    rec_t        e;
    sync = 24'hAAAAAB;
    n = int'(hdr[3:0]) + 1;
    for (int i = 23; i >= 0; i--) bits.push_back(sync[i]);
    for (int i = 7; i >= 0; i--) bits.push_back(hdr[i]);
    for (int i = 0; i < n * 8; i++) bits.push_back(pl[127-i]);
    for (int i = 7; i >= 0; i--) bits.push_back(crc_tx[i]);
    for (int i = 0; i < bits.size(); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rx_line = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_err = 8'h00;
        return;
      end
      if (i == 0) chk("busy_before_frame", 160'(rx_busy), 160'(1'b0));
      if (i == 24) chk("busy_in_header", 160'(rx_busy), 160'(1'b1));
      rx_line = bits[i];
    end
    mask  = ~({128{1'b1}} >> (n * 8));
    e.pkt = {hdr, pl & mask};
    e.ok  = (crc_tx == crc8_model(pl, n));
    e.hit = (hdr[7:6] == my_id);
    if (!e.ok && model_err != 8'hFF) model_err = model_err + 8'd1;
    e.err = model_err;
    e.cyc = cyc + 2;
    exp_q.push_back(e);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_line = 1'b0;
    end
  endtask

  task automatic check_results(input string tag);
    int m;
    repeat (4) begin
      @(negedge clk);
      rx_line = 1'b0;
    end
    chk({tag, "_valid_count"}, 160'(obs_q.size()), 160'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_packet"},   160'(obs_q[i].pkt), 160'(exp_q[i].pkt));
      chk({tag, "_crc_ok"},   160'(obs_q[i].ok),  160'(exp_q[i].ok));
      chk({tag, "_addr_hit"}, 160'(obs_q[i].hit), 160'(exp_q[i].hit));
      chk({tag, "_err_cnt"},  160'(obs_q[i].err), 160'(exp_q[i].err));
      chk({tag, "_latency"},  160'(obs_q[i].cyc), 160'(exp_q[i].cyc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, 160'({rx_packet, rx_valid, rx_crc_ok, rx_addr_hit, rx_busy, rx_err_cnt}), 160'(0));
  endtask

  initial begin
    logic [127:0] pl;
    logic [7:0]   hdr;
    logic [7:0]   crc;

    rst = 1'b1;
    rx_line = 1'b0;
    my_id = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_outputs");

    // Minimal frame, one byte, addressed to us.
    my_id = 2'd0;
    send_frame(8'h00, {8'h01, 120'h0}, 8'h07, 3, -1);
    check_results("min_frame");

    // Maximum length frame addressed elsewhere.
    my_id = 2'd2;
    pl = {128{1'b1}};
    send_frame(8'h4F, pl, crc8_model(pl, 16), 3, -1);
    check_results("max_frame");

    // Corrupted data bit, then saturation of the error counter.
    my_id = 2'd0;
    send_frame(8'h00, {8'h81, 120'h0}, 8'h07, 2, -1);
    check_results("crc_err");
    for (int i = 0; i < 255; i++) send_frame(8'h00, {8'h81, 120'h0}, 8'h07, 1, -1);
    check_results("crc_sat");
    chk("err_cnt_saturated", 160'(rx_err_cnt), 160'(model_err));

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, {8'hFF, 120'h0}, 8'hF3, 0, -1);
    send_frame(8'h00, {8'h00, 120'h0}, 8'h00, 3, -1);
    check_results("back_to_back");

    // Reset in the middle of the payload discards the frame.
    pl = {$urandom, $urandom, $urandom, $urandom};
    send_frame(8'h03, pl, crc8_model(pl, 4), 0, 24 + 8 + 5);
    check_all_zero("outputs_after_abort");
    check_results("aborted");
    pl = {8'h5A, 8'hC3, 112'h0};
    send_frame(8'h41, pl, crc8_model(pl, 2), 3, -1);
    check_results("after_abort");

    // Sync pattern embedded in payload is plain data.
    my_id = 2'd1;
    pl = {8'hAA, 8'hAB, 112'h0};
    send_frame(8'h01, pl, crc8_model(pl, 2), 3, -1);
    check_results("sync_in_payload");

    // Random frames, some with corrupted CRC.
    for (int f = 0; f < 20; f++) begin
      my_id = 2'($urandom_range(0, 3));
      hdr = 8'($urandom);
      pl  = {$urandom, $urandom, $urandom, $urandom};
      crc = crc8_model(pl, int'(hdr[3:0]) + 1);
      if ($urandom_range(0, 1) == 1) crc = crc ^ 8'($urandom_range(1, 255));
      send_frame(hdr, pl, crc, int'($urandom_range(2, 4)), -1);
    end
    check_results("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
